// File: rtl/seq_alu.sv
// seq_alu: handshaked eight-operation ALU with registered results and a
// multi-cycle shift-add multiplier. One operation is in flight at a time.
`default_nettype none

module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               carry,
  output logic               zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XNR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      iter;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   narrow;
  logic [2*WIDTH-1:0] op_y;
  logic               op_c;
  logic [2*WIDTH-1:0] acc_next;

  assign in_ready = (state == IDLE) && rst_n;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // The borrow out of the WIDTH+1-bit difference is exactly a < b.
  always_comb begin
    narrow = '0;
    op_c   = 1'b0;
    op_y   = '0;
    case (sel)
      OP_ADD: begin
        op_y = {{(WIDTH-1){1'b0}}, sum};
        op_c = sum[WIDTH];
      end
      OP_SUB: begin
        narrow = diff[WIDTH-1:0];
        op_c   = diff[WIDTH];
      end
      OP_AND:  narrow = a & b;
      OP_OR:   narrow = a | b;
      OP_XNR:  narrow = ~(a ^ b);
      OP_NOT:  narrow = ~a;
      OP_SHR:  narrow = b >> a[SHW-1:0];
      default: narrow = '0;
    endcase
    if (sel != OP_ADD) begin
      op_y = {{WIDTH{1'b0}}, narrow};
    end
  end

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      iter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (sel == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              iter   <= '0;
              state  <= MUL;
            end else begin
              y         <= op_y;
              carry     <= op_c;
              zero      <= (op_y == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          iter   <= iter + 1'b1;
          acc    <= acc_next;
          if (iter == LAST_ITER) begin
            y         <= acc_next;
            carry     <= 1'b0;
            zero      <= (acc_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at WIDTH = 8, plus WIDTH = 4 and 16.
`default_nettype none
`timescale 1ns/1ps

module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // WIDTH = 8 instance
  logic        iv8 = 0, ir8, ov8, or8 = 1, c8, z8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [2:0]  s8 = 0;
  logic [15:0] y8;
  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .sel(s8), .out_valid(ov8), .out_ready(or8), .y(y8), .carry(c8), .zero(z8)
  );

  // WIDTH = 4 instance
  logic        iv4 = 0, ir4, ov4, or4 = 1, c4, z4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [2:0]  s4 = 0;
  logic [7:0]  y4;
  seq_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .sel(s4), .out_valid(ov4), .out_ready(or4), .y(y4), .carry(c4), .zero(z4)
  );

  // WIDTH = 16 instance
  logic        iv16 = 0, ir16, ov16, or16 = 1, c16, z16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [2:0]  s16 = 0;
  logic [31:0] y16;
  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .sel(s16), .out_valid(ov16), .out_ready(or16), .y(y16), .carry(c16), .zero(z16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  sel;
    logic [15:0] y;
    logic        c;
    logic        z;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Latency counts edges after the accepting edge until out_valid is seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                      output logic [15:0] ry, output logic rc, output logic rz, output int lat);
    int t = 0;
    while (!ir8 && t < 50) begin @(posedge clk); #1; t++; end
    chk("ready8_before_op", ir8, 1);
    a8 = a; b8 = b; s8 = s; iv8 = 1; or8 = 1;
    @(posedge clk); #1;
    iv8 = 0; a8 = ~a; b8 = ~b;
    lat = 0;
    while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
    ry = y8; rc = c8; rz = z8;
    @(posedge clk); #1;
    chk("consumed8", {ov8, ir8}, 2'b01);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                      output logic [7:0] ry, output logic rc, output int lat);
    a4 = a; b4 = b; s4 = s; iv4 = 1;
    @(posedge clk); #1;
    iv4 = 0;
    lat = 0;
    while (!ov4 && lat < 100) begin @(posedge clk); #1; lat++; end
    ry = y4; rc = c4;
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s,
                       output logic [31:0] ry, output logic rc, output int lat);
    a16 = a; b16 = b; s16 = s; iv16 = 1;
    @(posedge clk); #1;
    iv16 = 0;
    lat = 0;
    while (!ov16 && lat < 100) begin @(posedge clk); #1; lat++; end
    ry = y16; rc = c16;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ry;
    logic [7:0]  ry4;
    logic [31:0] ry16;
    logic        rc, rz;
    int          lat;
    bit          saw_valid;

    vecs[0]  = '{8'hFF, 8'h01, 3'b000, 16'h0100, 1'b1, 1'b0, 0};
    vecs[1]  = '{8'h03, 8'h05, 3'b001, 16'h00FE, 1'b1, 1'b0, 0};
    vecs[2]  = '{8'h42, 8'h42, 3'b001, 16'h0000, 1'b0, 1'b1, 0};
    vecs[3]  = '{8'hFF, 8'hFF, 3'b010, 16'hFE01, 1'b0, 1'b0, 8};
    vecs[4]  = '{8'h00, 8'h37, 3'b010, 16'h0000, 1'b0, 1'b1, 8};
    vecs[5]  = '{8'h13, 8'h80, 3'b111, 16'h0010, 1'b0, 1'b0, 0};
    vecs[6]  = '{8'h0F, 8'h00, 3'b110, 16'h00F0, 1'b0, 1'b0, 0};
    vecs[7]  = '{8'h0F, 8'h33, 3'b101, 16'h00C3, 1'b0, 1'b0, 0};
    vecs[8]  = '{8'hF0, 8'h3C, 3'b011, 16'h0030, 1'b0, 1'b0, 0};
    vecs[9]  = '{8'h0F, 8'h30, 3'b100, 16'h003F, 1'b0, 1'b0, 0};
    vecs[10] = '{8'h7F, 8'h01, 3'b000, 16'h0080, 1'b0, 1'b0, 0};
    vecs[11] = '{8'h08, 8'hFF, 3'b111, 16'h00FF, 1'b0, 1'b0, 0};
    vecs[12] = '{8'h0D, 8'h0B, 3'b010, 16'h008F, 1'b0, 1'b0, 8};
    vecs[13] = '{8'h05, 8'h03, 3'b001, 16'h0002, 1'b0, 1'b0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {ov8, y8, c8, z8}, 19'd0);
    chk("reset_in_ready_low", ir8, 0);
    rst_n = 1;
    #1;
    chk("reset_in_ready_high", ir8, 1);

    for (int i = 0; i < NV; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].sel, ry, rc, rz, lat);
      chk($sformatf("v%0d_y", i), ry, vecs[i].y);
      chk($sformatf("v%0d_carry", i), rc, vecs[i].c);
      chk($sformatf("v%0d_zero", i), rz, vecs[i].z);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
    end

    // Backpressure: result held, new requests ignored
    or8 = 0; a8 = 8'h0F; b8 = 8'hF0; s8 = 3'b110; iv8 = 1;
    @(posedge clk); #1;
    iv8 = 0; a8 = 8'h55; s8 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_hold", i), {ov8, ir8, y8, c8, z8}, {1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0});
      iv8 = (i % 2 == 0);
      @(posedge clk); #1;
    end
    iv8 = 0; or8 = 1;
    @(posedge clk); #1;
    chk("bp_release", {ov8, ir8}, 2'b01);
    @(posedge clk); #1;
    chk("bp_no_phantom", {ov8, ir8}, 2'b01);

    // Reset in the middle of a multiply
    a8 = 8'hFF; b8 = 8'hFF; s8 = 3'b010; iv8 = 1;
    @(posedge clk); #1;
    iv8 = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mulrst_busy", {ov8, ir8}, 2'b00);
    rst_n = 0;
    #1;
    chk("mulrst_ready_in_reset", ir8, 0);
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    chk("mulrst_outputs", {ov8, y8, c8, z8}, 19'd0);
    chk("mulrst_ready", ir8, 1);
    saw_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8) saw_valid = 1;
    end
    chk("mulrst_no_result", saw_valid, 0);
    run8(8'h01, 8'h02, 3'b000, ry, rc, rz, lat);
    chk("post_rst_add", {ry, rc, rz}, {16'h0003, 1'b0, 1'b0});
    chk("post_rst_add_lat", lat, 0);

    // WIDTH = 4
    run4(4'hF, 4'hF, 3'b010, ry4, rc, lat);
    chk("w4_mul_y", ry4, 8'hE1);
    chk("w4_mul_lat", lat, 4);
    run4(4'hF, 4'h1, 3'b000, ry4, rc, lat);
    chk("w4_add_y", {ry4, rc}, {8'h10, 1'b1});
    chk("w4_add_lat", lat, 0);

    // WIDTH = 16
    run16(16'hFFFF, 16'hFFFF, 3'b010, ry16, rc, lat);
    chk("w16_mul_y", ry16, 32'hFFFE0001);
    chk("w16_mul_lat", lat, 16);
    run16(16'hFFFF, 16'h0001, 3'b000, ry16, rc, lat);
    chk("w16_add_y", {ry16, rc}, {32'h0001_0000, 1'b1});
    chk("w16_add_lat", lat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
